// File: rtl/pwm_counter_pkg.sv
// pwm_counter_pkg: shared widths and pwm_gen function bit indices for the PWM timebase
package pwm_counter_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int PRESC_W_DEF = 8;
  localparam int FN_RIGHT = 0;
  localparam int FN_NONALIGNED = 1;
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;
endpackage

// File: rtl/pwm_counter_if.sv
// pwm_counter_if: raw config from the register file in, active config and timebase out
interface pwm_counter_if
  import pwm_counter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
);
  logic               cnt_en;
  logic               cnt_clr;
  logic               up_ndown;
  logic               preload_en;
  logic [PRESC_W-1:0] prescale;
  logic [CNT_W-1:0]   period_in;
  logic [CNT_W-1:0]   compare1_in;
  logic [CNT_W-1:0]   compare2_in;
  logic [CNT_W-1:0]   count_val;
  logic [CNT_W-1:0]   period_act;
  logic [CNT_W-1:0]   compare1_act;
  logic [CNT_W-1:0]   compare2_act;
  logic               cnt_tick;
  logic               wrap_evt;
  modport master (
    output cnt_en, cnt_clr, up_ndown, preload_en, prescale, period_in, compare1_in, compare2_in,
    input  count_val, period_act, compare1_act, compare2_act, cnt_tick, wrap_evt
  );
  modport slave (
    input  cnt_en, cnt_clr, up_ndown, preload_en, prescale, period_in, compare1_in, compare2_in,
    output count_val, period_act, compare1_act, compare2_act, cnt_tick, wrap_evt
  );
endinterface

// File: rtl/pwm_counter_prescaler.sv
// pwm_counter_prescaler: divides clk by prescale+1; a shrunk prescale ticks on the next enabled cycle
module pwm_counter_prescaler
  import pwm_counter_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic               tick_o
);
  logic [PRESC_W-1:0] presc_q, presc_d;
  always_comb begin
    tick_o = en_i && !clr_i && (presc_q >= prescale_i);
    presc_d = (clr_i || tick_o) ? '0 : en_i ? presc_q + PRESC_W'(1) : presc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else presc_q <= presc_d;
  end
endmodule

// File: rtl/pwm_counter.sv
// pwm_counter: prescaled up/down timebase with wrap-synchronised shadow config for pwm_gen
module pwm_counter
  import pwm_counter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input logic clk,
  input logic rst,
  pwm_counter_if.slave bus
);
  logic             tick, at_end, load;
  logic [CNT_W-1:0] count_q, count_d, period_q, period_d, cmp1_q, cmp1_d, cmp2_q, cmp2_d;
  logic             tick_q, tick_d, wrap_q, wrap_d;
  pwm_counter_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk       (clk),
    .rst       (rst),
    .en_i      (bus.cnt_en),
    .clr_i     (bus.cnt_clr),
    .prescale_i(bus.prescale),
    .tick_o    (tick)
  );
  // Shadows load on clear, every cycle without preload, or on the wrap tick with preload
  always_comb begin
    at_end = (bus.up_ndown == DIR_UP) ? (count_q >= period_q) : (count_q == '0);
    tick_d = tick;
    wrap_d = tick && at_end;
    load = bus.cnt_clr || !bus.preload_en || wrap_d;
    period_d = load ? bus.period_in : period_q;
    cmp1_d = load ? bus.compare1_in : cmp1_q;
    cmp2_d = load ? bus.compare2_in : cmp2_q;
    count_d = bus.cnt_clr ? ((bus.up_ndown == DIR_UP) ? '0 : bus.period_in)
            : !tick ? count_q
            : (bus.up_ndown == DIR_UP) ? (at_end ? '0 : count_q + CNT_W'(1))
            : at_end ? (bus.preload_en ? bus.period_in : period_q)
            : count_q - CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      period_q <= '0;
      cmp1_q <= '0;
      cmp2_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      count_q <= count_d;
      period_q <= period_d;
      cmp1_q <= cmp1_d;
      cmp2_q <= cmp2_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end
  assign bus.count_val = count_q;
  assign bus.period_act = period_q;
  assign bus.compare1_act = cmp1_q;
  assign bus.compare2_act = cmp2_q;
  assign bus.cnt_tick = tick_q;
  assign bus.wrap_evt = wrap_q;
endmodule

// File: tb/tb_pwm_counter.sv
// tb_pwm_counter: directed scenarios plus a randomized run against a behavioural timebase model
module tb_pwm_counter;
  typedef logic [15:0] w_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  pwm_counter_if bus ();
  pwm_counter dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [7:0] presc, input w_t per, input logic up, input logic pre);
    bus.prescale = presc;
    bus.period_in = per;
    bus.up_ndown = up;
    bus.preload_en = pre;
    bus.cnt_en = 1'b0;
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.cnt_en = 1'b1;
    bus.cnt_clr = 1'b0;
    bus.up_ndown = 1'b1;
    bus.preload_en = 1'b0;
    bus.prescale = 8'd0;
    bus.period_in = 16'd7;
    bus.compare1_in = 16'd3;
    bus.compare2_in = 16'd5;
    rst = 1'b1;
    step();
    step();
    n_cmp += 1;
    if (bus.count_val !== 16'd0 || bus.cnt_tick !== 1'b0 || bus.wrap_evt !== 1'b0) begin
      n_err += 1;
      $display("FAIL reset_counter: count=%0d tick=%b wrap=%b, required 0 0 0", bus.count_val, bus.cnt_tick, bus.wrap_evt);
    end
    n_cmp += 1;
    if (bus.period_act !== 16'd0 || bus.compare1_act !== 16'd0 || bus.compare2_act !== 16'd0) begin
      n_err += 1;
      $display("FAIL reset_shadow: per=%0d c1=%0d c2=%0d, required 0 0 0", bus.period_act, bus.compare1_act, bus.compare2_act);
    end
    rst = 1'b0;
  endtask

  task automatic test_up_count();
    w_t exp_c[6] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd1};
    logic exp_w[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    setup(8'd0, 16'd4, 1'b1, 1'b0);
    n_cmp += 1;
    if (bus.count_val !== 16'd0 || bus.period_act !== 16'd4) begin
      n_err += 1;
      $display("FAIL up_clr: count=%0d per=%0d, required 0 4", bus.count_val, bus.period_act);
    end
    bus.cnt_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp += 1;
      if (bus.count_val !== exp_c[i] || bus.wrap_evt !== exp_w[i] || bus.cnt_tick !== 1'b1) begin
        n_err += 1;
        $display("FAIL up_seq[%0d]: count=%0d wrap=%b tick=%b, required %0d %b 1", i, bus.count_val, bus.wrap_evt, bus.cnt_tick, exp_c[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_prescale();
    w_t exp_c[9] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd3};
    logic exp_t[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    setup(8'd2, 16'd3, 1'b1, 1'b0);
    bus.cnt_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      n_cmp += 1;
      if (bus.count_val !== exp_c[i] || bus.cnt_tick !== exp_t[i] || bus.wrap_evt !== 1'b0) begin
        n_err += 1;
        $display("FAIL presc_seq[%0d]: count=%0d tick=%b wrap=%b, required %0d %b 0", i, bus.count_val, bus.cnt_tick, bus.wrap_evt, exp_c[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_down();
    w_t exp_c[5] = '{16'd2, 16'd1, 16'd0, 16'd3, 16'd2};
    logic exp_w[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    setup(8'd0, 16'd3, 1'b0, 1'b0);
    n_cmp += 1;
    if (bus.count_val !== 16'd3) begin
      n_err += 1;
      $display("FAIL down_clr: count=%0d, required 3", bus.count_val);
    end
    bus.cnt_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp += 1;
      if (bus.count_val !== exp_c[i] || bus.wrap_evt !== exp_w[i]) begin
        n_err += 1;
        $display("FAIL down_seq[%0d]: count=%0d wrap=%b, required %0d %b", i, bus.count_val, bus.wrap_evt, exp_c[i], exp_w[i]);
      end
    end
    setup(8'd0, 16'd0, 1'b0, 1'b0);
    bus.cnt_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) bus.up_ndown = 1'b1;
      step();
      n_cmp += 1;
      if (bus.count_val !== 16'd0 || bus.wrap_evt !== 1'b1 || bus.cnt_tick !== 1'b1) begin
        n_err += 1;
        $display("FAIL period0[%0d]: count=%0d wrap=%b tick=%b, required 0 1 1", i, bus.count_val, bus.wrap_evt, bus.cnt_tick);
      end
    end
  endtask

  task automatic test_preload();
    bus.compare1_in = 16'd2;
    bus.compare2_in = 16'd6;
    setup(8'd0, 16'd10, 1'b1, 1'b1);
    bus.cnt_en = 1'b1;
    repeat (3) step();
    bus.period_in = 16'd5;
    bus.compare1_in = 16'd1;
    bus.compare2_in = 16'd4;
    for (int i = 0; i < 7; i++) begin
      step();
      n_cmp += 1;
      if (bus.count_val !== w_t'(4 + i) || bus.period_act !== 16'd10 || bus.compare1_act !== 16'd2 || bus.compare2_act !== 16'd6 || bus.wrap_evt !== 1'b0) begin
        n_err += 1;
        $display("FAIL preload_hold[%0d]: count=%0d per=%0d c1=%0d c2=%0d wrap=%b, required %0d 10 2 6 0", i, bus.count_val, bus.period_act, bus.compare1_act, bus.compare2_act, bus.wrap_evt, 4 + i);
      end
    end
    step();
    n_cmp += 1;
    if (bus.count_val !== 16'd0 || bus.wrap_evt !== 1'b1 || bus.period_act !== 16'd5 || bus.compare1_act !== 16'd1 || bus.compare2_act !== 16'd4) begin
      n_err += 1;
      $display("FAIL preload_wrap: count=%0d wrap=%b per=%0d c1=%0d c2=%0d, required 0 1 5 1 4", bus.count_val, bus.wrap_evt, bus.period_act, bus.compare1_act, bus.compare2_act);
    end
    repeat (5) step();
    n_cmp += 1;
    if (bus.count_val !== 16'd5 || bus.wrap_evt !== 1'b0) begin
      n_err += 1;
      $display("FAIL preload_new_top: count=%0d wrap=%b, required 5 0", bus.count_val, bus.wrap_evt);
    end
    step();
    n_cmp += 1;
    if (bus.count_val !== 16'd0 || bus.wrap_evt !== 1'b1) begin
      n_err += 1;
      $display("FAIL preload_new_wrap: count=%0d wrap=%b, required 0 1", bus.count_val, bus.wrap_evt);
    end
    setup(8'd0, 16'd10, 1'b1, 1'b0);
    bus.cnt_en = 1'b1;
    repeat (3) step();
    bus.period_in = 16'd5;
    step();
    n_cmp += 1;
    if (bus.count_val !== 16'd4 || bus.period_act !== 16'd5) begin
      n_err += 1;
      $display("FAIL direct_update: count=%0d per=%0d, required 4 5", bus.count_val, bus.period_act);
    end
    step();
    step();
    n_cmp += 1;
    if (bus.count_val !== 16'd0 || bus.wrap_evt !== 1'b1) begin
      n_err += 1;
      $display("FAIL direct_wrap: count=%0d wrap=%b, required 0 1", bus.count_val, bus.wrap_evt);
    end
  endtask

  task automatic test_hold();
    setup(8'd1, 16'd20, 1'b1, 1'b0);
    bus.cnt_en = 1'b1;
    repeat (15) step();
    n_cmp += 1;
    if (bus.count_val !== 16'd7) begin
      n_err += 1;
      $display("FAIL hold_start: count=%0d, required 7", bus.count_val);
    end
    bus.cnt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp += 1;
      if (bus.count_val !== 16'd7 || bus.cnt_tick !== 1'b0 || bus.wrap_evt !== 1'b0) begin
        n_err += 1;
        $display("FAIL hold[%0d]: count=%0d tick=%b wrap=%b, required 7 0 0", i, bus.count_val, bus.cnt_tick, bus.wrap_evt);
      end
    end
    bus.cnt_en = 1'b1;
    step();
    n_cmp += 1;
    if (bus.count_val !== 16'd8 || bus.cnt_tick !== 1'b1) begin
      n_err += 1;
      $display("FAIL hold_resume: count=%0d tick=%b, required 8 1", bus.count_val, bus.cnt_tick);
    end
  endtask

  task automatic test_clr();
    setup(8'd0, 16'd20, 1'b1, 1'b0);
    bus.cnt_en = 1'b1;
    repeat (9) step();
    rst = 1'b1;
    bus.cnt_clr = 1'b1;
    step();
    rst = 1'b0;
    bus.cnt_clr = 1'b0;
    n_cmp += 1;
    if (bus.count_val !== 16'd0 || bus.period_act !== 16'd0 || bus.compare1_act !== 16'd0 || bus.cnt_tick !== 1'b0) begin
      n_err += 1;
      $display("FAIL rst_over_clr: count=%0d per=%0d c1=%0d tick=%b, required 0 0 0 0", bus.count_val, bus.period_act, bus.compare1_act, bus.cnt_tick);
    end
    setup(8'd0, 16'd20, 1'b0, 1'b0);
    bus.cnt_en = 1'b1;
    repeat (11) step();
    n_cmp += 1;
    if (bus.count_val !== 16'd9) begin
      n_err += 1;
      $display("FAIL clr_pre: count=%0d, required 9", bus.count_val);
    end
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    n_cmp += 1;
    if (bus.count_val !== 16'd20 || bus.wrap_evt !== 1'b0 || bus.cnt_tick !== 1'b0) begin
      n_err += 1;
      $display("FAIL clr_down: count=%0d wrap=%b tick=%b, required 20 0 0", bus.count_val, bus.wrap_evt, bus.cnt_tick);
    end
  endtask

  task automatic test_random();
    w_t m_cnt, m_per, m_c1, m_c2;
    logic [7:0] m_presc;
    logic m_tick, m_wrap, t;
    rst = 1'b1;
    bus.cnt_clr = 1'b0;
    step();
    rst = 1'b0;
    {m_cnt, m_per, m_c1, m_c2, m_presc, m_tick, m_wrap} = '0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.cnt_clr = ($urandom_range(0, 59) == 0);
      bus.cnt_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) bus.up_ndown = ~bus.up_ndown;
      if ($urandom_range(0, 29) == 0) bus.preload_en = ~bus.preload_en;
      if ($urandom_range(0, 19) == 0) bus.prescale = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        bus.period_in = w_t'($urandom_range(0, 9));
        bus.compare1_in = w_t'($urandom);
        bus.compare2_in = w_t'($urandom);
      end
      if (rst) begin
        {m_cnt, m_per, m_c1, m_c2, m_presc, m_tick, m_wrap} = '0;
      end else if (bus.cnt_clr) begin
        m_presc = '0;
        m_cnt = bus.up_ndown ? 16'd0 : bus.period_in;
        {m_per, m_c1, m_c2} = {bus.period_in, bus.compare1_in, bus.compare2_in};
        {m_tick, m_wrap} = 2'b00;
      end else begin
        t = bus.cnt_en && (m_presc >= bus.prescale);
        if (bus.cnt_en) m_presc = t ? 8'd0 : m_presc + 8'd1;
        m_wrap = 1'b0;
        if (t && bus.up_ndown) begin
          m_wrap = (m_cnt >= m_per);
          m_cnt = m_wrap ? 16'd0 : m_cnt + 16'd1;
        end else if (t) begin
          m_wrap = (m_cnt == 16'd0);
          m_cnt = !m_wrap ? m_cnt - 16'd1 : bus.preload_en ? bus.period_in : m_per;
        end
        if (!bus.preload_en || m_wrap) {m_per, m_c1, m_c2} = {bus.period_in, bus.compare1_in, bus.compare2_in};
        m_tick = t;
      end
      step();
      n_cmp += 1;
      if (bus.count_val !== m_cnt || bus.cnt_tick !== m_tick || bus.wrap_evt !== m_wrap) begin
        n_err += 1;
        $display("FAIL rand_count[%0d]: count=%0d tick=%b wrap=%b, required %0d %b %b", i, bus.count_val, bus.cnt_tick, bus.wrap_evt, m_cnt, m_tick, m_wrap);
      end
      n_cmp += 1;
      if (bus.period_act !== m_per || bus.compare1_act !== m_c1 || bus.compare2_act !== m_c2) begin
        n_err += 1;
        $display("FAIL rand_shadow[%0d]: per=%0d c1=%0d c2=%0d, required %0d %0d %0d", i, bus.period_act, bus.compare1_act, bus.compare2_act, m_per, m_c1, m_c2);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_prescale();
    test_down();
    test_preload();
    test_hold();
    test_clr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
